// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: frame geometry, default baud
// timing and the receive state machine encoding.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 139;   // 16 MHz / 115200

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    // Counter value at which the start bit is re-checked (its middle).
    function automatic int half_bit_last(input int clks_per_bit);
        return clks_per_bit / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte delivery interface between the UART receiver (master) and the core
// that consumes bytes (slave). data is qualified by valid; ready accepts.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data,
        output valid,
        output frame_err,
        output overrun,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  frame_err,
        input  overrun,
        output ready
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input. Both flops reset
// to RESET_VAL so an idle-high pin does not look like an edge on release.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);
    logic r_s1;
    logic r_s2;

    // shift the raw input through two flops to settle metastability
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= RESET_VAL;
            r_s2 <= RESET_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The raw pin is synchronised internally, the start bit
// is re-validated at its middle, data and stop bits are sampled at the end
// of each bit period counted from there, and completed bytes are presented
// through a single holding register with a valid/ready handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam logic [CNT_W-1:0] LP_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] LP_HALF_LAST = CNT_W'(half_bit_last(CLKS_PER_BIT));
    localparam logic [2:0]       LP_IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 w_rx_s2;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_idx_next;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_next;
    logic                 w_complete;
    logic                 w_stop_bad;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (rx),
        .o_q     (w_rx_s2)
    );

    // state machine and bit-timing registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    // next-state logic: frame sequencing, bit sampling and completion flags
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_complete     = 1'b0;
        w_stop_bad     = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx_s2) begin
                    w_state_next = START;
                    w_cnt_next   = '0;
                end
            end

            START: begin
                if (r_cnt == LP_HALF_LAST) begin
                    w_cnt_next = '0;
                    if (!w_rx_s2) begin
                        w_state_next   = DATA;
                        w_bit_idx_next = '0;
                    end else begin
                        // line went back high before mid-bit: a glitch
                        w_state_next = IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            DATA: begin
                if (r_cnt == LP_BIT_LAST) begin
                    w_cnt_next     = '0;
                    w_shift_next   = {w_rx_s2, r_shift[DATA_BITS-1:1]};
                    w_bit_idx_next = r_bit_idx + 1'b1;
                    if (r_bit_idx == LP_IDX_LAST) begin
                        w_state_next = STOP;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            STOP: begin
                if (r_cnt == LP_BIT_LAST) begin
                    w_cnt_next = '0;
                    if (w_rx_s2) begin
                        w_complete   = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_stop_bad   = 1'b1;
                        w_state_next = WAIT_HIGH;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            WAIT_HIGH: begin
                // hold off until the line returns idle so a break is one error
                if (w_rx_s2) begin
                    w_state_next = IDLE;
                end
            end

            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // holding register, handshake and one-cycle status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            r_overrun   <= w_complete && r_valid && !bus.ready;
            if (w_complete && (!r_valid || bus.ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && bus.ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx at 16 clocks per bit. A
// frame-level model (one-deep holding queue) predicts delivered bytes,
// overruns and framing errors; a monitor records what the DUT produces.
module tb_uart_rx;
    localparam int CPB = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rx      = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    int         cyc       = 0;
    logic [7:0] got_q[$];
    int         fe_cnt    = 0;
    int         ov_cnt    = 0;
    int         both_cnt  = 0;
    int         vhi_cnt   = 0;
    int         rise_cyc  = -1;
    logic       prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        if (bus.valid && bus.ready) got_q.push_back(bus.data);
        if (bus.frame_err) fe_cnt++;
        if (bus.overrun) ov_cnt++;
        if (bus.frame_err && bus.overrun) both_cnt++;
        if (bus.valid) vhi_cnt++;
        if (bus.valid && !prev_valid) rise_cyc = cyc;
        prev_valid = bus.valid;
    end

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    logic [7:0] hold_q[$];
    int         exp_fe = 0;
    int         exp_ov = 0;

    // A good frame completes; rdy is the consumer's ready at that moment.
    function automatic void model_byte(input logic [7:0] b, input logic rdy);
        if (hold_q.size() == 0) begin
            hold_q.push_back(b);
        end else if (rdy) begin
            exp_q.push_back(hold_q.pop_front());
            hold_q.push_back(b);
        end else begin
            exp_ov++;
        end
    endfunction

    // Consumer is ready with time to spare: pending byte gets taken.
    function automatic void model_drain();
        if (hold_q.size() != 0) exp_q.push_back(hold_q.pop_front());
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_deliveries(input string tag);
        chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        $display("[%0d] %s: delivered %0d byte(s), expected %0d", cyc, tag, got_q.size(), exp_q.size());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_frame_err"}, fe_cnt, exp_fe);
        chk({tag, "_overrun"}, ov_cnt, exp_ov);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, bus.data, 8'h00);
        chk({tag, "_valid"}, bus.valid, 1'b0);
        chk({tag, "_frame_err"}, bus.frame_err, 1'b0);
        chk({tag, "_overrun"}, bus.overrun, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    // Called at a negedge; drives one 8N1 frame, optionally with a low stop.
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        $display("[%0d] send 0x%02h stop_low=%0d", cyc, b, stop_low);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            repeat (stop_low) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    int         t0;
    int         lat;
    int         vhi0;
    int         fe0;
    logic [7:0] rb;

    initial begin
        bus.ready = 1'b1;
        reset_n   = 1'b0;
        rx        = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // back-to-back frames, consumer always ready, first-byte latency
        vhi0 = vhi_cnt;
        t0   = cyc;
        send_frame(8'h55, 0);
        lat  = rise_cyc - t0;
        model_byte(8'h55, 1'b1); model_drain();
        send_frame(8'hA3, 0);
        model_byte(8'hA3, 1'b1); model_drain();
        repeat (4) @(negedge clk);
        #2;
        chk("first_valid_latency", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
        chk("valid_high_cycles", vhi_cnt - vhi0, 2);
        check_deliveries("b2b");
        check_status("b2b");

        // consumer stalled: second byte overruns, first byte kept
        @(negedge clk);
        bus.ready = 1'b0;
        send_frame(8'h12, 0);
        model_byte(8'h12, 1'b0);
        send_frame(8'h34, 0);
        model_byte(8'h34, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        check_status("stall");
        chk("stall_valid", bus.valid, hold_q.size() != 0);
        if (hold_q.size() != 0) chk("stall_data", bus.data, hold_q[0]);
        @(negedge clk);
        bus.ready = 1'b1;
        model_drain();
        repeat (3) @(negedge clk);
        #2;
        chk("after_handshake_valid", bus.valid, 1'b0);
        chk("after_handshake_data_held", bus.data, 8'h12);
        check_deliveries("stall");

        // short glitch on idle line is ignored
        @(negedge clk);
        vhi0 = vhi_cnt;
        rx   = 1'b0;
        repeat (5) @(negedge clk);
        rx   = 1'b1;
        repeat (30) @(negedge clk);
        #2;
        chk("glitch_no_valid", vhi_cnt - vhi0, 0);
        check_status("glitch");
        @(negedge clk);
        send_frame(8'h7E, 0);
        model_byte(8'h7E, 1'b1); model_drain();
        repeat (4) @(negedge clk);
        #2;
        check_deliveries("after_glitch");

        // stop bit held low (break): single frame error, no byte
        @(negedge clk);
        vhi0 = vhi_cnt;
        send_frame(8'hFF, 40);
        exp_fe++;
        repeat (20) @(negedge clk);
        #2;
        chk("break_no_valid", vhi_cnt - vhi0, 0);
        check_status("break");
        @(negedge clk);
        send_frame(8'h81, 0);
        model_byte(8'h81, 1'b1); model_drain();
        repeat (4) @(negedge clk);
        #2;
        check_deliveries("after_break");
        check_status("after_break");

        // reset asserted in the middle of a frame
        @(negedge clk);
        fork
            send_frame(8'hC6, 0);
            begin
                repeat (60) @(negedge clk);
                reset_n = 1'b0;
                #2;
                check_reset_outputs("midframe_reset");
            end
        join
        hold_q.delete();
        #2;
        check_reset_outputs("held_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h3C, 0);
        model_byte(8'h3C, 1'b1); model_drain();
        repeat (4) @(negedge clk);
        #2;
        check_deliveries("after_reset");
        check_status("after_reset");

        // completion in the same cycle as a handshake of the pending byte
        @(negedge clk);
        bus.ready = 1'b0;
        send_frame(8'h01, 0);
        model_byte(8'h01, 1'b0);
        #2;
        chk("pending_valid", bus.valid, 1'b1);
        chk("pending_data", bus.data, 8'h01);
        @(negedge clk);
        fork
            send_frame(8'h02, 0);
            begin
                repeat (154) @(negedge clk);
                bus.ready = 1'b1;
                @(negedge clk);
                bus.ready = 1'b0;
            end
        join
        model_byte(8'h02, 1'b1);
        #2;
        chk("coincide_valid", bus.valid, hold_q.size() != 0);
        if (hold_q.size() != 0) chk("coincide_data", bus.data, hold_q[0]);
        check_status("coincide");
        @(negedge clk);
        bus.ready = 1'b1;
        model_drain();
        repeat (3) @(negedge clk);
        #2;
        check_deliveries("coincide");

        // random bytes with random idle gaps, consumer ready
        @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            rb = 8'($urandom);
            send_frame(rb, 0);
            model_byte(rb, 1'b1); model_drain();
        end
        repeat (4) @(negedge clk);
        #2;
        check_deliveries("random");
        check_status("random");
        chk("err_and_overrun_exclusive", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
